profile_inst_checker: RTL and testbench
=======================================

# profile_inst_checker

Lockstep commit checker that consumes a pre-recorded commit trace (one record = 32-bit instruction word + 7-bit exception code, the same record content the commit profiler emits per retired instruction) over a valid/ready stream and compares it, in program order, against the core's live dual-issue commit ports. It sits beside the commit stage, buffers a few trace records ahead, and reports the first divergence (wrong instruction/exception, or the trace running dry) with full expected/actual context. It is synthesizable, so trace replay works on FPGA as well as in simulation.

## Interface
- DEPTH, 4: trace prefetch buffer entries; power of two, >= 2.
- CNT_W, 32: width of the checked-instruction counter.

- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cmt_valid0 / cmt_valid1  in  1  live commit slot 0 / slot 1 valid; slot 0 is older.
- cmt_inst0 / cmt_inst1  in  32  committed instruction word per slot.
- cmt_excp0 / cmt_excp1  in  7  committed exception code per slot.
- ref_valid  in  1  trace record offered.
- ref_ready  out  1  record accepted when ref_valid && ref_ready.
- ref_inst  in  32  expected instruction word.
- ref_excp  in  7  expected exception code.
- ref_last  in  1  record is the final one of the trace.
- err_valid  out  1  sticky; divergence detected.
- err_code  out  2  0 none, 1 mismatch, 2 underrun (commit with no buffered record), 3 overrun (commit after last record checked).
- err_slot  out  1  commit slot that failed.
- err_exp_inst / err_exp_excp  out  32 / 7  expected record at failure (0 for codes 2, 3).
- err_act_inst / err_act_excp  out  32 / 7  live commit at failure.
- checked_cnt  out  CNT_W  instructions matched so far.
- done  out  1  sticky; last record matched with no error.

## Operation
- Buffer: DEPTH-entry circular FIFO, head/tail pointers plus count (log2(DEPTH)+1 bits). ref_ready = (count < DEPTH) && state==RUN && !last_seen. last_seen set when a record with ref_last=1 is accepted; stored per entry as a last bit.
- No bypass: records accepted in cycle t are comparable from cycle t+1 only.
- Per cycle in RUN, n = cmt_valid0 + cmt_valid1. Live commits ordered slot 0 then slot 1; slot 1 alone (valid0=0) is the first live commit.
- First live commit compared to head entry, second to head+1 (mod DEPTH). Match = inst and all 7 excp bits equal.
- Evaluation order per live commit: if the matching entry does not exist (count at cycle start too small) -> overrun if last already checked, else underrun; else if unequal -> mismatch; else match.
- First failing commit (older slot wins) is captured into err_*; commits before it count as checked and are popped; the failing and later commits are not.
- Matched entries popped; pop and push in same cycle allowed (count += push - pops).
- States: RUN (reset), ERROR, DONE.
  - RUN -> ERROR on any failure; err_valid=1, err_code set.
  - RUN -> DONE when a popped entry has last=1 and no failure that cycle. If slot 0 matches the last record and slot 1 is also valid, slot 1 is an overrun -> ERROR, code 3.
  - DONE -> ERROR (code 3) on any live commit. ERROR is terminal until reset.
- In ERROR and DONE, FIFO frozen, ref_ready=0, checked_cnt frozen.
- checked_cnt adds 0/1/2 per cycle, wraps modulo 2^CNT_W.

## Timing
- All outputs registered; reset values: ref_ready 0 during reset then 1 in cycle after release (count=0), all err_* 0, checked_cnt 0, done 0, pointers/count 0.
- Latency: commit in cycle t -> checked_cnt, err_*, done visible at t+1.
- ref_ready reflects count/state at cycle start; not dependent on same-cycle pops (no combinational path from cmt_* to ref_ready).
- Reset asserted mid-trace: FIFO flushed, state RUN, all sticky outputs cleared asynchronously.

## Test plan
- Push records A=(0x02800413,0x00), B=(0x00000013,0x00); commit A slot0 and B slot1 in one cycle -> next cycle checked_cnt=2, err_valid=0, count=0.
- Buffer 2 records; commit slot0 matching, slot1 inst 0x00100093 vs expected 0x00000013 -> err_code=1, err_slot=1, err_exp_inst=0x00000013, err_act_inst=0x00100093, checked_cnt=1, ref_ready=0 thereafter.
- Empty FIFO, push and commit same cycle -> underrun: err_code=2, err_slot=0, err_exp_*=0, checked_cnt=0.
- Fill DEPTH=4 records with ref_valid held high -> ref_ready falls after 4th accept; one single-slot commit per cycle -> FIFO drains/refills, pointers wrap, 12 records checked with no error.
- Record 3 with ref_last=1; match all three -> done=1; later commit -> err_code=3, done stays 1; assert rstn mid-operation -> all outputs 0, checking restarts from fresh trace.
- Exception-only mismatch: inst equal, expected excp 0x00, actual 0x0B -> err_code=1, err_act_excp=0x0B.

Source files
------------

// File: rtl/profile_inst_checker.sv
`default_nettype none
// ============================================================================
// Module   : profile_inst_checker
// Purpose  : Lockstep checker comparing a buffered commit trace against the
//            live dual-issue commit ports; latches the first divergence.
// Revision : 1.0 - initial release
// ============================================================================
module profile_inst_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmt_valid0,
    input  logic             cmt_valid1,
    input  logic [31:0]      cmt_inst0,
    input  logic [31:0]      cmt_inst1,
    input  logic [6:0]       cmt_excp0,
    input  logic [6:0]       cmt_excp1,
    input  logic             ref_valid,
    output logic             ref_ready,
    input  logic [31:0]      ref_inst,
    input  logic [6:0]       ref_excp,
    input  logic             ref_last,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic             err_slot,
    output logic [31:0]      err_exp_inst,
    output logic [6:0]       err_exp_excp,
    output logic [31:0]      err_act_inst,
    output logic [6:0]       err_act_excp,
    output logic [CNT_W-1:0] checked_cnt,
    output logic             done
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;

    localparam logic [1:0] c_ERR_NONE     = 2'd0;
    localparam logic [1:0] c_ERR_MISMATCH = 2'd1;
    localparam logic [1:0] c_ERR_UNDERRUN = 2'd2;
    localparam logic [1:0] c_ERR_OVERRUN  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ERROR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_BITS-1:0]   r_count;
    logic                  r_last_seen;
    logic                  r_ref_ready;
    logic                  r_err_valid;
    logic [1:0]            r_err_code;
    logic                  r_err_slot;
    logic [31:0]           r_err_exp_inst;
    logic [6:0]            r_err_exp_excp;
    logic [31:0]           r_err_act_inst;
    logic [6:0]            r_err_act_excp;
    logic [CNT_W-1:0]      r_checked;
    logic                  r_done;

    logic [31:0]           r_mem_inst [DEPTH];
    logic [6:0]            r_mem_excp [DEPTH];
    logic                  r_mem_last [DEPTH];

    logic                  w_push;
    logic [PTR_W-1:0]      w_head1;
    logic                  w_f_valid;
    logic                  w_f_slot;
    logic [31:0]           w_f_inst;
    logic [6:0]            w_f_excp;
    logic                  w_s_valid;
    logic                  w_avail0;
    logic                  w_avail1;
    logic                  w_eq0;
    logic                  w_eq1;

    logic                  w_fail;
    logic [1:0]            w_code;
    logic                  w_slot;
    logic [31:0]           w_exp_inst;
    logic [6:0]            w_exp_excp;
    logic [31:0]           w_act_inst;
    logic [6:0]            w_act_excp;
    logic [1:0]            w_pops;
    logic                  w_last_pop;

    state_t                w_state_next;
    logic [CNT_BITS-1:0]   w_count_next;
    logic                  w_last_seen_next;
    logic                  w_ready_next;

    // ref_ready is registered, so a push is always accepted into a free slot
    assign w_push    = ref_valid && r_ref_ready;
    assign w_head1   = r_head + 1'b1;

    // Slot 1 alone is the first live commit
    assign w_f_valid = cmt_valid0 || cmt_valid1;
    assign w_f_slot  = !cmt_valid0;
    assign w_f_inst  = cmt_valid0 ? cmt_inst0 : cmt_inst1;
    assign w_f_excp  = cmt_valid0 ? cmt_excp0 : cmt_excp1;
    assign w_s_valid = cmt_valid0 && cmt_valid1;

    assign w_avail0  = (r_count != '0);
    assign w_avail1  = (r_count >= CNT_BITS'(2));
    assign w_eq0     = (r_mem_inst[r_head]  == w_f_inst)  && (r_mem_excp[r_head]  == w_f_excp);
    assign w_eq1     = (r_mem_inst[w_head1] == cmt_inst1) && (r_mem_excp[w_head1] == cmt_excp1);

    always_comb begin
        w_fail     = 1'b0;
        w_code     = c_ERR_NONE;
        w_slot     = 1'b0;
        w_exp_inst = '0;
        w_exp_excp = '0;
        w_act_inst = '0;
        w_act_excp = '0;
        w_pops     = 2'd0;
        w_last_pop = 1'b0;
        if (r_state == ST_RUN) begin
            if (w_f_valid) begin
                if (!w_avail0) begin
                    w_fail     = 1'b1;
                    w_code     = c_ERR_UNDERRUN;
                    w_slot     = w_f_slot;
                    w_act_inst = w_f_inst;
                    w_act_excp = w_f_excp;
                end else if (!w_eq0) begin
                    w_fail     = 1'b1;
                    w_code     = c_ERR_MISMATCH;
                    w_slot     = w_f_slot;
                    w_exp_inst = r_mem_inst[r_head];
                    w_exp_excp = r_mem_excp[r_head];
                    w_act_inst = w_f_inst;
                    w_act_excp = w_f_excp;
                end else begin
                    w_pops     = 2'd1;
                    w_last_pop = r_mem_last[r_head];
                    if (w_s_valid) begin
                        w_slot     = 1'b1;
                        w_act_inst = cmt_inst1;
                        w_act_excp = cmt_excp1;
                        if (r_mem_last[r_head]) begin
                            w_fail = 1'b1;
                            w_code = c_ERR_OVERRUN;
                        end else if (!w_avail1) begin
                            w_fail = 1'b1;
                            w_code = c_ERR_UNDERRUN;
                        end else if (!w_eq1) begin
                            w_fail     = 1'b1;
                            w_code     = c_ERR_MISMATCH;
                            w_exp_inst = r_mem_inst[w_head1];
                            w_exp_excp = r_mem_excp[w_head1];
                        end else begin
                            w_pops     = 2'd2;
                            w_last_pop = r_mem_last[w_head1];
                        end
                    end
                end
            end
        end else if ((r_state == ST_DONE) && w_f_valid) begin
            w_fail     = 1'b1;
            w_code     = c_ERR_OVERRUN;
            w_slot     = w_f_slot;
            w_act_inst = w_f_inst;
            w_act_excp = w_f_excp;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_fail) begin
            w_state_next = ST_ERROR;
        end else if ((r_state == ST_RUN) && w_last_pop) begin
            w_state_next = ST_DONE;
        end
    end

    assign w_count_next     = r_count + CNT_BITS'(w_push) - CNT_BITS'(w_pops);
    assign w_last_seen_next = r_last_seen || (w_push && ref_last);
    assign w_ready_next     = (w_state_next == ST_RUN) && (w_count_next < CNT_BITS'(DEPTH)) &&
                              !w_last_seen_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_RUN;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_last_seen    <= 1'b0;
            r_ref_ready    <= 1'b0;
            r_err_valid    <= 1'b0;
            r_err_code     <= c_ERR_NONE;
            r_err_slot     <= 1'b0;
            r_err_exp_inst <= '0;
            r_err_exp_excp <= '0;
            r_err_act_inst <= '0;
            r_err_act_excp <= '0;
            r_checked      <= '0;
            r_done         <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_head      <= r_head + PTR_W'(w_pops);
            r_tail      <= r_tail + PTR_W'(w_push);
            r_count     <= w_count_next;
            r_last_seen <= w_last_seen_next;
            r_ref_ready <= w_ready_next;
            r_checked   <= r_checked + CNT_W'(w_pops);
            if (w_fail) begin
                r_err_valid    <= 1'b1;
                r_err_code     <= w_code;
                r_err_slot     <= w_slot;
                r_err_exp_inst <= w_exp_inst;
                r_err_exp_excp <= w_exp_excp;
                r_err_act_inst <= w_act_inst;
                r_err_act_excp <= w_act_excp;
            end
            if ((r_state == ST_RUN) && (w_state_next == ST_DONE)) begin
                r_done <= 1'b1;
            end
        end
    end

    // Trace storage needs no reset: entries are only read when count covers them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_tail] <= ref_inst;
            r_mem_excp[r_tail] <= ref_excp;
            r_mem_last[r_tail] <= ref_last;
        end
    end

    assign ref_ready    = r_ref_ready;
    assign err_valid    = r_err_valid;
    assign err_code     = r_err_code;
    assign err_slot     = r_err_slot;
    assign err_exp_inst = r_err_exp_inst;
    assign err_exp_excp = r_err_exp_excp;
    assign err_act_inst = r_err_act_inst;
    assign err_act_excp = r_err_act_excp;
    assign checked_cnt  = r_checked;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_profile_inst_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_profile_inst_checker
// Purpose  : Table-driven and sequence checks of the lockstep commit checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_profile_inst_checker;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmt_valid0 = 1'b0, cmt_valid1 = 1'b0;
    logic [31:0] cmt_inst0 = '0, cmt_inst1 = '0;
    logic [6:0]  cmt_excp0 = '0, cmt_excp1 = '0;
    logic        ref_valid = 1'b0;
    logic        ref_ready;
    logic [31:0] ref_inst = '0;
    logic [6:0]  ref_excp = '0;
    logic        ref_last = 1'b0;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        err_slot;
    logic [31:0] err_exp_inst, err_act_inst;
    logic [6:0]  err_exp_excp, err_act_excp;
    logic [31:0] checked_cnt;
    logic        done;

    profile_inst_checker #(.DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .cmt_valid0(cmt_valid0), .cmt_valid1(cmt_valid1),
        .cmt_inst0(cmt_inst0), .cmt_inst1(cmt_inst1),
        .cmt_excp0(cmt_excp0), .cmt_excp1(cmt_excp1),
        .ref_valid(ref_valid), .ref_ready(ref_ready),
        .ref_inst(ref_inst), .ref_excp(ref_excp), .ref_last(ref_last),
        .err_valid(err_valid), .err_code(err_code), .err_slot(err_slot),
        .err_exp_inst(err_exp_inst), .err_exp_excp(err_exp_excp),
        .err_act_inst(err_act_inst), .err_act_excp(err_act_excp),
        .checked_cnt(checked_cnt), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rv;
        logic [31:0] ri;
        bit          rl;
        bit          v0;
        logic [31:0] i0;
        logic [6:0]  e0;
        bit          v1;
        logic [31:0] i1;
        logic [6:0]  e1;
        bit          x_rdy;
        int          x_cnt;
        bit          x_ev;
        logic [1:0]  x_code;
        bit          x_slot;
        bit          x_done;
        logic [31:0] x_einst;
        logic [31:0] x_ainst;
        logic [6:0]  x_aexcp;
    } vec_t;

    localparam logic [31:0] c_A = 32'h0280_0413;
    localparam logic [31:0] c_B = 32'h0000_0013;
    localparam logic [31:0] c_C = 32'h0010_0093;
    localparam logic [31:0] c_D = 32'h00a0_0513;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.rst = 0; v.rv = 0; v.ri = '0; v.rl = 0;
        v.v0 = 0; v.i0 = '0; v.e0 = '0; v.v1 = 0; v.i1 = '0; v.e1 = '0;
        v.x_rdy = 0; v.x_cnt = 0; v.x_ev = 0; v.x_code = 2'd0; v.x_slot = 0;
        v.x_done = 0; v.x_einst = '0; v.x_ainst = '0; v.x_aexcp = '0;
        return v;
    endfunction

    function automatic vec_t f_rst();
        vec_t v = blank();
        v.rst = 1;
        return v;
    endfunction

    function automatic vec_t f_push(input logic [31:0] ri, input bit rl);
        vec_t v = blank();
        v.rv = 1; v.ri = ri; v.rl = rl;
        return v;
    endfunction

    function automatic vec_t f_cmt(input bit v0, input logic [31:0] i0, input logic [6:0] e0,
                                   input bit v1, input logic [31:0] i1, input logic [6:0] e1);
        vec_t v = blank();
        v.v0 = v0; v.i0 = i0; v.e0 = e0; v.v1 = v1; v.i1 = i1; v.e1 = e1;
        return v;
    endfunction

    function automatic vec_t ok(input vec_t v, input bit rdy, input int cnt, input bit dn);
        v.x_rdy = rdy; v.x_cnt = cnt; v.x_done = dn;
        return v;
    endfunction

    function automatic vec_t er(input vec_t v, input bit rdy, input int cnt, input logic [1:0] code,
                                input bit slot, input bit dn, input logic [31:0] ei,
                                input logic [31:0] ai, input logic [6:0] ae);
        v.x_rdy = rdy; v.x_cnt = cnt; v.x_ev = 1; v.x_code = code; v.x_slot = slot;
        v.x_done = dn; v.x_einst = ei; v.x_ainst = ai; v.x_aexcp = ae;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rstn       = v.rst ? 1'b0 : 1'b1;
        ref_valid  = v.rv; ref_inst = v.ri; ref_excp = '0; ref_last = v.rl;
        cmt_valid0 = v.v0; cmt_inst0 = v.i0; cmt_excp0 = v.e0;
        cmt_valid1 = v.v1; cmt_inst1 = v.i1; cmt_excp1 = v.e1;
        exp_q.push_back(v);
        if (v.rst) begin
            #1;
            chk($sformatf("v%0d.async_err", idx), {31'd0, err_valid}, 32'd0);
            chk($sformatf("v%0d.async_done", idx), {31'd0, done}, 32'd0);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d.ready", idx), {31'd0, ref_ready}, {31'd0, e.x_rdy});
        chk($sformatf("v%0d.checked", idx), checked_cnt, e.x_cnt);
        chk($sformatf("v%0d.err_valid", idx), {31'd0, err_valid}, {31'd0, e.x_ev});
        chk($sformatf("v%0d.err_code", idx), {30'd0, err_code}, {30'd0, e.x_code});
        chk($sformatf("v%0d.err_slot", idx), {31'd0, err_slot}, {31'd0, e.x_slot});
        chk($sformatf("v%0d.done", idx), {31'd0, done}, {31'd0, e.x_done});
        chk($sformatf("v%0d.exp_inst", idx), err_exp_inst, e.x_einst);
        chk($sformatf("v%0d.exp_excp", idx), {25'd0, err_exp_excp}, 32'd0);
        chk($sformatf("v%0d.act_inst", idx), err_act_inst, e.x_ainst);
        chk($sformatf("v%0d.act_excp", idx), {25'd0, err_act_excp}, {25'd0, e.x_aexcp});
    endtask

    task automatic idle_inputs();
        ref_valid = 0; ref_last = 0; ref_inst = '0; ref_excp = '0;
        cmt_valid0 = 0; cmt_valid1 = 0;
    endtask

    initial begin
        // Dual commit of A,B
        tbl.push_back(ok(f_rst(), 0, 0, 0));
        tbl.push_back(ok(blank(), 1, 0, 0));
        tbl.push_back(ok(f_push(c_A, 0), 1, 0, 0));
        tbl.push_back(ok(f_push(c_B, 0), 1, 0, 0));
        tbl.push_back(ok(f_cmt(1, c_A, 7'h00, 1, c_B, 7'h00), 1, 2, 0));
        // Slot 1 mismatch, then frozen
        tbl.push_back(ok(f_rst(), 0, 0, 0));
        tbl.push_back(ok(blank(), 1, 0, 0));
        tbl.push_back(ok(f_push(c_A, 0), 1, 0, 0));
        tbl.push_back(ok(f_push(c_B, 0), 1, 0, 0));
        tbl.push_back(er(f_cmt(1, c_A, 7'h00, 1, c_C, 7'h00), 0, 1, 2'd1, 1, 0, c_B, c_C, 7'h00));
        tbl.push_back(er(f_push(c_D, 0), 0, 1, 2'd1, 1, 0, c_B, c_C, 7'h00));
        // Underrun: push and commit in the same cycle
        tbl.push_back(ok(f_rst(), 0, 0, 0));
        tbl.push_back(ok(blank(), 1, 0, 0));
        begin
            vec_t v = f_cmt(1, c_A, 7'h00, 0, '0, '0);
            v.rv = 1; v.ri = c_A;
            tbl.push_back(er(v, 0, 0, 2'd2, 0, 0, 32'd0, c_A, 7'h00));
        end
        // Exception-only mismatch, slot 1 alone
        tbl.push_back(ok(f_rst(), 0, 0, 0));
        tbl.push_back(ok(blank(), 1, 0, 0));
        tbl.push_back(ok(f_push(c_B, 0), 1, 0, 0));
        tbl.push_back(er(f_cmt(0, '0, '0, 1, c_B, 7'h0B), 0, 0, 2'd1, 1, 0, c_B, c_B, 7'h0B));
        // Done, then overrun; reset mid-operation and restart
        tbl.push_back(ok(f_rst(), 0, 0, 0));
        tbl.push_back(ok(blank(), 1, 0, 0));
        tbl.push_back(ok(f_push(c_A, 0), 1, 0, 0));
        tbl.push_back(ok(f_push(c_B, 0), 1, 0, 0));
        tbl.push_back(ok(f_push(c_C, 1), 0, 0, 0));
        tbl.push_back(ok(f_cmt(1, c_A, 7'h00, 0, '0, '0), 0, 1, 0));
        tbl.push_back(ok(f_cmt(1, c_B, 7'h00, 1, c_C, 7'h00), 0, 3, 1));
        tbl.push_back(er(f_cmt(1, c_D, 7'h00, 0, '0, '0), 0, 3, 2'd3, 0, 1, 32'd0, c_D, 7'h00));
        tbl.push_back(ok(f_rst(), 0, 0, 0));
        tbl.push_back(ok(blank(), 1, 0, 0));
        tbl.push_back(ok(f_push(c_A, 0), 1, 0, 0));
        tbl.push_back(ok(f_cmt(1, c_A, 7'h00, 0, '0, '0), 1, 1, 0));
        // Slot 0 matches the last record, slot 1 overruns
        tbl.push_back(ok(f_rst(), 0, 0, 0));
        tbl.push_back(ok(blank(), 1, 0, 0));
        tbl.push_back(ok(f_push(c_A, 1), 0, 0, 0));
        tbl.push_back(er(f_cmt(1, c_A, 7'h00, 1, c_B, 7'h00), 0, 1, 2'd3, 1, 0, 32'd0, c_B, 7'h00));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Fill to DEPTH, then single-slot drain/refill across pointer wrap
        begin
            int acc = 0, popped = 0, mcount = 0;
            bit mrdy;
            int expq[$];
            @(negedge clk); rstn = 0; idle_inputs();
            @(negedge clk); rstn = 1;
            @(posedge clk); #1;
            mrdy = 1;
            chk("fill.ready0", {31'd0, ref_ready}, 32'd1);
            for (int c = 0; c < 6; c++) begin
                bit pushed;
                @(negedge clk);
                ref_valid = 1; ref_inst = 32'h1000_0000 | acc; ref_excp = 7'(acc); ref_last = 0;
                pushed = mrdy;
                @(posedge clk); #1;
                if (pushed) begin acc++; mcount++; end
                mrdy = (mcount < 4);
                chk($sformatf("fill%0d.ready", c), {31'd0, ref_ready}, {31'd0, mrdy});
            end
            for (int c = 0; c < 60 && popped < 12; c++) begin
                bit pushed, pop;
                @(negedge clk);
                pushed = mrdy && (acc < 16);
                pop = (mcount > 0);
                ref_valid = pushed; ref_inst = 32'h1000_0000 | acc; ref_excp = 7'(acc);
                cmt_valid0 = pop; cmt_inst0 = 32'h1000_0000 | popped; cmt_excp0 = 7'(popped);
                cmt_valid1 = 0;
                expq.push_back(popped + (pop ? 1 : 0));
                @(posedge clk); #1;
                if (pushed) begin acc++; mcount++; end
                if (pop) begin popped++; mcount--; end
                mrdy = (mcount < 4);
                chk($sformatf("drain%0d.checked", c), checked_cnt, expq.pop_front());
                chk($sformatf("drain%0d.ready", c), {31'd0, ref_ready}, {31'd0, mrdy});
                chk($sformatf("drain%0d.err", c), {31'd0, err_valid}, 32'd0);
            end
            idle_inputs();
            if (popped < 12) begin
                n_cmp++; n_fail++;
                $display("FAIL drain_timeout: got %0d checked expected 12", popped);
            end
            @(posedge clk); #1;
            chk("drain.final_cnt", checked_cnt, 32'd12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
